uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to 1 (idle line level).
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start/data/parity/stop frames into a parallel byte
// with a one-cycle valid strobe and sticky-until-next-frame error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = int'(PAR_EVEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_state_e          r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;

  uart_sync2 u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (rx_in),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (!w_rx_s) r_state <= START;
        end
        START: begin
          if (r_clk_cnt == CNT_HALF) begin
            // A line that is high again at mid start bit was only a glitch.
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? IDLE : DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == IDX_LAST) begin
              r_bit_idx <= '0;
              r_state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
            r_par_bad <= ((^r_shift) ^ w_rx_s) != 1'(PARITY_ODD);
            r_state   <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt    <= '0;
            r_data       <= r_shift;
            r_valid      <= 1'b1;
            r_parity_err <= (PARITY_EN != 0) ? r_par_bad : 1'b0;
            r_frame_err  <= !w_rx_s;
            // A low stop bit means a held-low line; wait for idle before rearming.
            r_state      <= w_rx_s ? IDLE : BREAK;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected results queued per frame
// and compared whenever the receiver strobes rx_valid.
module tb_uart_rx;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   vcnt  = 0;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .PARITY_EN    (1),
    .PARITY_ODD   (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = flip_par;
    e.ferr = !stop;
    q.push_back(e);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time((^d) ^ flip_par);
    bit_time(stop);
  endtask

  // Scoreboard: every rx_valid must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      exp_t e;
      vcnt++;
      chk("valid_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("parity_err", 32'(parity_err), 32'(e.perr));
        chk("frame_err", 32'(frame_err), 32'(e.ferr));
      end
    end
  end

  initial begin
    int v0;
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("good_vcnt", 32'(vcnt), 32'd1);
    chk("good_busy_after", 32'(busy), 32'h0);

    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("par_vcnt", 32'(vcnt), 32'd2);
    chk("par_err_held", 32'(parity_err), 32'h1);

    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    chk("break_vcnt", 32'(vcnt), 32'd3);
    chk("break_busy", 32'(busy), 32'h1);
    chk("break_ferr_held", 32'(frame_err), 32'h1);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_release_busy", 32'(busy), 32'h0);
    repeat (2 * CPB) @(negedge clk);

    v0 = vcnt;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    for (int i = 0; i < CPB / 2 + 3; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("glitch_busy_drop", 32'(busy), 32'h0);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_no_valid", 32'(vcnt), 32'(v0));

    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("b2b_vcnt", 32'(vcnt), 32'd5);
    chk("b2b_last_data", 32'(rx_data), 32'hFF);

    v0 = vcnt;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b1);
    rx_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rx_data", 32'(rx_data), 32'h0);
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("midrst_no_valid", 32'(vcnt), 32'(v0));
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("after_rst_vcnt", 32'(vcnt), 32'd6);
    chk("after_rst_data", 32'(rx_data), 32'h5A);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
